// File: rtl/dp_ram_fifo_ctrl.sv
// FWFT FIFO controller over a dual-port RAM macro (write port B, read port A).
// The RAM holds the bulk data. A 2-entry skid buffer in front of the read
// side hides the 1-cycle RAM read latency, so one push and one pop can
// happen every cycle.
module dp_ram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  RD_VALID,
  input  logic                  RD_READY,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [ADDR_WIDTH+1:0] COUNT,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic                  CEA,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [DATA_WIDTH-1:0] DB,
  output logic [DATA_WIDTH-1:0] BWB,
  output logic                  CEB,
  input  logic [DATA_WIDTH-1:0] QA
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_rd_pend;
  logic [1:0]            r_out_cnt;
  logic [DATA_WIDTH-1:0] r_skid0;
  logic [DATA_WIDTH-1:0] r_skid1;
  logic [ADDR_WIDTH+1:0] r_count;

  logic                  w_wr_ready;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fetch;
  logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;
  logic [1:0]            w_out_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_skid0_nxt;
  logic [DATA_WIDTH-1:0] w_skid1_nxt;
  logic [ADDR_WIDTH+1:0] w_count_nxt;

  // Handshakes and RAM fetch decision; a fetch is only issued when the skid
  // buffer is guaranteed room for the returning word.
  always_comb begin
    w_wr_ready = !RST && (r_ram_cnt < DEPTH_C);
    w_push     = WR_VALID && w_wr_ready;
    w_pop      = (r_out_cnt != 2'd0) && RD_READY;
    w_fetch    = !RST && (r_ram_cnt != '0) &&
                 (({1'b0, r_out_cnt} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop}));
  end

  // Next-state for occupancy counters and the skid buffer contents.
  always_comb begin
    w_ram_cnt_nxt = r_ram_cnt;
    case ({w_push, w_fetch})
      2'b10:   w_ram_cnt_nxt = r_ram_cnt + 1'b1;
      2'b01:   w_ram_cnt_nxt = r_ram_cnt - 1'b1;
      default: w_ram_cnt_nxt = r_ram_cnt;
    endcase

    w_out_cnt_nxt = r_out_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};

    // Returning RAM data lands in the first slot left free after any pop.
    w_skid0_nxt = r_skid0;
    w_skid1_nxt = r_skid1;
    case (r_out_cnt)
      2'd0: begin
        if (r_rd_pend) w_skid0_nxt = QA;
      end
      2'd1: begin
        if (r_rd_pend && w_pop)       w_skid0_nxt = QA;
        else if (r_rd_pend && !w_pop) w_skid1_nxt = QA;
      end
      default: begin
        if (w_pop) begin
          w_skid0_nxt = r_skid1;
          if (r_rd_pend) w_skid1_nxt = QA;
        end
      end
    endcase

    w_count_nxt = {1'b0, w_ram_cnt_nxt} + (ADDR_WIDTH + 2)'(w_fetch) +
                  (ADDR_WIDTH + 2)'(w_out_cnt_nxt);
  end

  // State registers; reset drops everything including a read in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_out_cnt <= '0;
      r_skid0   <= '0;
      r_skid1   <= '0;
      r_count   <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fetch) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ram_cnt <= w_ram_cnt_nxt;
      r_rd_pend <= w_fetch;
      r_out_cnt <= w_out_cnt_nxt;
      r_skid0   <= w_skid0_nxt;
      r_skid1   <= w_skid1_nxt;
      r_count   <= w_count_nxt;
    end
  end

  // Output mapping onto the handshake pair and the RAM ports.
  always_comb begin
    WR_READY = w_wr_ready;
    RD_VALID = (r_out_cnt != 2'd0);
    RD_DATA  = r_skid0;
    COUNT    = r_count;
    AA       = r_rd_ptr;
    CEA      = w_fetch;
    AB       = r_wr_ptr;
    DB       = WR_DATA;
    CEB      = w_push;
    BWB      = {DATA_WIDTH{w_push}};
  end

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Bench for dp_ram_fifo_ctrl: RAM macro model, queue-based reference model
// checked every cycle, and directed sequences with literal expectations.
module tb_dp_ram_fifo_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          WR_VALID = 1'b0;
  logic          WR_READY;
  logic [DW-1:0] WR_DATA = '0;
  logic          RD_VALID;
  logic          RD_READY = 1'b0;
  logic [DW-1:0] RD_DATA;
  logic [AW+1:0] COUNT;
  logic [AW-1:0] AA;
  logic          CEA;
  logic [AW-1:0] AB;
  logic [DW-1:0] DB;
  logic [DW-1:0] BWB;
  logic          CEB;
  logic [DW-1:0] QA = '0;

  logic [DW-1:0] mem [DEPTH];

  int n_cmp  = 0;
  int n_fail = 0;

  dp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_DATA(WR_DATA),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA),
    .COUNT(COUNT), .AA(AA), .CEA(CEA), .AB(AB), .DB(DB), .BWB(BWB),
    .CEB(CEB), .QA(QA)
  );

  always #5 CLK = ~CLK;

  // RAM macro: registered read on port A, bit-masked write on port B
  always @(posedge CLK) begin
    if (CEB) mem[AB] <= (mem[AB] & ~BWB) | (DB & BWB);
    if (CEA) QA <= mem[AA];
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  task automatic tmo(string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s @%0t: bound expired", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] q[$];
  logic [DW-1:0] hold = '0;
  int  pushes_sr = 0;
  int  fetch_sr  = 0;
  int  streak    = 0;
  int  max_count = 0;
  bit  model_on  = 1'b0;

  always @(negedge CLK) begin
    if (RST) begin
      model_on = 1'b1;
      chk("rst_cea", 64'(CEA), 64'd0);
      chk("rst_ceb", 64'(CEB), 64'd0);
      chk("rst_bwb", 64'(BWB), 64'd0);
      chk("rst_wr_ready", 64'(WR_READY), 64'd0);
      q.delete();
      hold      = '0;
      pushes_sr = 0;
      fetch_sr  = 0;
      streak    = 0;
    end else if (model_on) begin
      // words held = accepted pushes minus accepted pops
      chk("count", 64'(COUNT), 64'(q.size()));
      if (int'(COUNT) > max_count) max_count = int'(COUNT);
      chk("count_bound", 64'(int'(COUNT) <= DEPTH + 2), 64'd1);
      // words sitting in RAM = written minus read out
      chk("wr_ready", 64'(WR_READY), 64'((pushes_sr - fetch_sr) < DEPTH));
      chk("ceb", 64'(CEB), 64'(WR_VALID && ((pushes_sr - fetch_sr) < DEPTH)));
      if (CEB) begin
        chk("ab", 64'(AB), 64'(pushes_sr % DEPTH));
        chk("db", 64'(DB), 64'(WR_DATA));
        chk("bwb_on", 64'(BWB), 64'(32'hFFFF_FFFF));
      end else begin
        chk("bwb_off", 64'(BWB), 64'd0);
      end
      if (CEA) begin
        chk("aa", 64'(AA), 64'(fetch_sr % DEPTH));
        chk("read_written", 64'(fetch_sr < pushes_sr), 64'd1);
      end
      if (RD_VALID) begin
        streak = 0;
        chk("rd_valid_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) chk("rd_data", 64'(RD_DATA), 64'(q[0]));
      end else begin
        chk("rd_hold", 64'(RD_DATA), 64'(hold));
        if (q.size() != 0) begin
          streak++;
          chk("rd_latency", 64'(streak <= 2), 64'd1);
        end else begin
          streak = 0;
        end
      end
      if (WR_VALID && WR_READY) begin
        q.push_back(WR_DATA);
        pushes_sr++;
      end
      if (CEA) fetch_sr++;
      if (RD_VALID && RD_READY && q.size() != 0) hold = q.pop_front();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    int  k;
    int  sent;
    int  got;
    int  first;
    int  gaps;
    int  stalls;
    bit  full;
    bit  acc;

    // 1: reset
    RST = 1'b1; WR_VALID = 1'b1; WR_DATA = 32'hDEAD_BEEF; RD_READY = 1'b0;
    repeat (3) begin
      smp();
      chk("t1_cea", 64'(CEA), 64'd0);
      chk("t1_ceb", 64'(CEB), 64'd0);
      chk("t1_wr_ready", 64'(WR_READY), 64'd0);
      tick();
    end
    RST = 1'b0; WR_VALID = 1'b0;
    smp();
    chk("t1_rd_valid", 64'(RD_VALID), 64'd0);
    chk("t1_count", 64'(COUNT), 64'd0);
    chk("t1_wr_ready_after", 64'(WR_READY), 64'd1);

    // 2: single push latency
    tick(); WR_VALID = 1'b1; WR_DATA = 32'hA5A5_0001; RD_READY = 1'b1;
    smp();
    chk("t2_ceb_c0", 64'(CEB), 64'd1);
    chk("t2_ab_c0", 64'(AB), 64'd0);
    tick(); WR_VALID = 1'b0;
    smp();
    chk("t2_cea_c1", 64'(CEA), 64'd1);
    chk("t2_aa_c1", 64'(AA), 64'd0);
    chk("t2_count_c1", 64'(COUNT), 64'd1);
    tick(); smp();
    chk("t2_rd_valid_c2", 64'(RD_VALID), 64'd0);
    chk("t2_count_c2", 64'(COUNT), 64'd1);
    tick(); smp();
    chk("t2_rd_valid_c3", 64'(RD_VALID), 64'd1);
    chk("t2_rd_data_c3", 64'(RD_DATA), 64'(32'hA5A5_0001));
    tick(); smp();
    chk("t2_rd_valid_c4", 64'(RD_VALID), 64'd0);
    chk("t2_count_c4", 64'(COUNT), 64'd0);

    // 3: fill with no pops, then drain
    tick(); RD_READY = 1'b0; WR_VALID = 1'b1; WR_DATA = 32'd0;
    k = 0; full = 1'b0;
    for (int c = 0; c < 60 && !full; c++) begin
      smp();
      if (WR_READY) k++;
      else full = 1'b1;
      if (!full) begin
        tick();
        WR_DATA = DW'(k);
      end
    end
    if (!full) tmo("t3_fill");
    chk("t3_accepted", 64'(k), 64'd18);
    chk("t3_count_full", 64'(COUNT), 64'd18);
    tick(); smp();
    chk("t3_wr_ready_held", 64'(WR_READY), 64'd0);
    chk("t3_count_held", 64'(COUNT), 64'd18);
    tick(); WR_VALID = 1'b0; RD_READY = 1'b1;
    for (int i = 0; i < 18; i++) begin
      smp();
      chk("t3_drain_valid", 64'(RD_VALID), 64'd1);
      chk("t3_drain_data", 64'(RD_DATA), 64'(i));
      tick();
    end
    smp();
    chk("t3_empty_valid", 64'(RD_VALID), 64'd0);
    chk("t3_empty_count", 64'(COUNT), 64'd0);

    // 4: streaming 100 words
    tick(); RD_READY = 1'b1; WR_VALID = 1'b1; WR_DATA = 32'd0;
    sent = 0; got = 0; first = -1; gaps = 0; stalls = 0;
    for (int c = 0; c < 300 && got < 100; c++) begin
      smp();
      if (WR_VALID && WR_READY) sent++;
      if (WR_VALID && !WR_READY) stalls++;
      if (RD_VALID) begin
        chk("t4_stream_data", 64'(RD_DATA), 64'(got));
        if (first < 0) first = c;
        got++;
      end else if (first >= 0) begin
        gaps++;
      end
      tick();
      if (sent < 100) WR_DATA = DW'(sent);
      else WR_VALID = 1'b0;
    end
    if (got < 100) tmo("t4_stream");
    chk("t4_got", 64'(got), 64'd100);
    chk("t4_first_valid", 64'(first), 64'd3);
    chk("t4_gaps", 64'(gaps), 64'd0);
    chk("t4_stalls", 64'(stalls), 64'd0);
    WR_VALID = 1'b0;

    // 5: random traffic, checked by the model
    WR_VALID = 1'b0; RD_READY = 1'b0; sent = 0; acc = 1'b0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      tick();
      if (!(WR_VALID && !acc)) begin
        WR_VALID = ($urandom_range(0, 1) == 1);
        WR_DATA  = $urandom;
      end
      RD_READY = ($urandom_range(0, 1) == 1);
      smp();
      acc = WR_VALID && WR_READY;
      if (acc) sent++;
    end
    if (sent < 10000) tmo("t5_random");
    tick(); WR_VALID = 1'b0; RD_READY = 1'b1;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      smp();
      if (COUNT == '0) break;
      tick();
    end
    chk("t5_drained", 64'(COUNT), 64'd0);
    chk("t5_max_count", 64'(max_count <= DEPTH + 2), 64'd1);

    // 6: reset mid-operation with a read in flight
    tick(); RD_READY = 1'b0; WR_VALID = 1'b1;
    for (int i = 0; i < 11; i++) begin
      WR_DATA = 32'h600 + DW'(i);
      smp();
      chk("t6_push_ready", 64'(WR_READY), 64'd1);
      tick();
    end
    WR_VALID = 1'b0;
    repeat (3) begin smp(); tick(); end
    smp();
    chk("t6_count11", 64'(COUNT), 64'd11);
    tick(); RD_READY = 1'b1;
    smp();
    chk("t6_pop_data", 64'(RD_DATA), 64'(32'h600));
    tick(); RD_READY = 1'b0; RST = 1'b1;
    smp();
    chk("t6_count10", 64'(COUNT), 64'd10);
    tick(); RST = 1'b0;
    smp();
    chk("t6_post_count", 64'(COUNT), 64'd0);
    chk("t6_post_valid", 64'(RD_VALID), 64'd0);
    tick(); WR_VALID = 1'b1; WR_DATA = 32'h77; RD_READY = 1'b1;
    smp();
    tick(); WR_VALID = 1'b0;
    smp();
    chk("t6_valid_q1", 64'(RD_VALID), 64'd0);
    tick(); smp();
    chk("t6_valid_q2", 64'(RD_VALID), 64'd0);
    tick(); smp();
    chk("t6_valid_q3", 64'(RD_VALID), 64'd1);
    chk("t6_data_q3", 64'(RD_DATA), 64'(32'h77));
    tick(); smp();
    chk("t6_final_count", 64'(COUNT), 64'd0);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog @%0t: simulation did not complete", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
